// File: rtl/xdat_arb_pkg.sv
// rtl/xdat_arb_pkg.sv - shared types and constants for the xdat SRAM arbiter
package xdat_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CPU = 2'd1,
        RD_DMA = 2'd2
    } owner_e;

    localparam int         XDAT_DEPTH = 1536;
    localparam logic [7:0] OOR_RDATA  = 8'hFF;

endpackage

// File: rtl/xdat_arb_starve.sv
// rtl/xdat_arb_starve.sv - DMA starvation counter and forced-grant decision
module xdat_arb_starve #(
    parameter int STARVE_MAX = 4
) (
    input  logic i_clk,
    input  logic i_rstz,
    input  logic dma_req,
    input  logic dma_gnt,
    input  logic hold_off,
    output logic force_dma
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    // hold_off keeps a pending CPU write ahead of a DMA read of the same word
    assign force_dma = dma_req && (starve_cnt == CNT_MAX) && !hold_off;

    always_ff @(posedge i_clk or negedge i_rstz) begin
        if (!i_rstz) begin
            starve_cnt <= '0;
        end else if (!dma_req || dma_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/xdat_arb.sv
// rtl/xdat_arb.sv - CPU/DMA arbiter for a single-port SRAM; XDAT_ARB_STARVE_EN enables DMA anti-starvation
module xdat_arb
    import xdat_arb_pkg::*;
#(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = XDAT_DEPTH,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_rstz,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_a,
    input  logic [DATA_W-1:0] cpu_wd,
    output logic              cpu_gnt,
    output logic              cpu_rvld,
    output logic [DATA_W-1:0] cpu_rd,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_a,
    input  logic [DATA_W-1:0] dma_wd,
    output logic              dma_gnt,
    output logic              dma_rvld,
    output logic [DATA_W-1:0] dma_rd,
    output logic              SRAM_CEB,
    output logic              SRAM_WEB,
    output logic              SRAM_OEB,
    output logic [ADDR_W-1:0] SRAM_A,
    output logic [DATA_W-1:0] SRAM_D,
    input  logic [DATA_W-1:0] SRAM_RDAT,
    output logic              err_oor,
    output logic              starve_hit
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic              force_dma;
    logic              any_gnt;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_d;
    logic              oor;
    logic [ADDR_W-1:0] a_q;
    logic [DATA_W-1:0] d_q;
    logic              oor_q;
    logic [DATA_W-1:0] rdat_sel;
    logic [DATA_W-1:0] cpu_rd_q;
    logic [DATA_W-1:0] dma_rd_q;
    owner_e            state_q;
    owner_e            state_d;

`ifdef XDAT_ARB_STARVE_EN
    logic hold_off;

    assign hold_off = cpu_req && cpu_we && !dma_we && (cpu_a == dma_a);

    xdat_arb_starve #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .i_clk    (i_clk),
        .i_rstz   (i_rstz),
        .dma_req  (dma_req),
        .dma_gnt  (dma_gnt),
        .hold_off (hold_off),
        .force_dma(force_dma)
    );
`else
    assign force_dma = 1'b0;
`endif

    // Grants are gated by reset so the whole interface is quiet while held in reset
    assign cpu_gnt    = i_rstz && cpu_req && !force_dma;
    assign dma_gnt    = i_rstz && dma_req && (!cpu_req || force_dma);
    assign starve_hit = i_rstz && force_dma && cpu_req;
    assign any_gnt    = cpu_gnt || dma_gnt;

    assign sel_we = cpu_gnt ? cpu_we : dma_we;
    assign sel_a  = cpu_gnt ? cpu_a  : dma_a;
    assign sel_d  = cpu_gnt ? cpu_wd : dma_wd;
    assign oor    = ({1'b0, sel_a} >= DEPTH_L);

    assign err_oor  = any_gnt && oor;
    assign SRAM_CEB = !(any_gnt && !oor);
    assign SRAM_WEB = !(any_gnt && sel_we);
    assign SRAM_OEB = !(any_gnt && !sel_we);
    assign SRAM_A   = any_gnt ? sel_a : a_q;
    assign SRAM_D   = any_gnt ? sel_d : d_q;

    always_ff @(posedge i_clk or negedge i_rstz) begin
        if (!i_rstz) begin
            a_q   <= '0;
            d_q   <= '0;
            oor_q <= 1'b0;
        end else if (any_gnt) begin
            a_q   <= sel_a;
            d_q   <= sel_d;
            oor_q <= oor;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstz) begin
        if (!i_rstz) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (cpu_gnt && !cpu_we) begin
            state_d = RD_CPU;
        end else if (dma_gnt && !dma_we) begin
            state_d = RD_DMA;
        end
    end

    assign rdat_sel = oor_q ? DATA_W'(OOR_RDATA) : SRAM_RDAT;
    assign cpu_rvld = (state_q == RD_CPU);
    assign dma_rvld = (state_q == RD_DMA);
    assign cpu_rd   = cpu_rvld ? rdat_sel : cpu_rd_q;
    assign dma_rd   = dma_rvld ? rdat_sel : dma_rd_q;

    always_ff @(posedge i_clk or negedge i_rstz) begin
        if (!i_rstz) begin
            cpu_rd_q <= '0;
            dma_rd_q <= '0;
        end else begin
            cpu_rd_q <= cpu_rd;
            dma_rd_q <= dma_rd;
        end
    end

endmodule

// File: tb/tb_xdat_arb.sv
// tb/tb_xdat_arb.sv - directed self-checking bench for xdat_arb with a behavioural SRAM
module tb_xdat_arb;

    logic        clk;
    logic        rstz;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvld;
    logic [10:0] cpu_a;
    logic [7:0]  cpu_wd, cpu_rd;
    logic        dma_req, dma_we, dma_gnt, dma_rvld;
    logic [10:0] dma_a;
    logic [7:0]  dma_wd, dma_rd;
    logic        sram_ceb, sram_web, sram_oeb;
    logic [10:0] sram_a;
    logic [7:0]  sram_d, sram_rdat;
    logic        err_oor, starve_hit;

    int vec;
    int miss;

    logic [7:0] mem [0:1535];

    xdat_arb dut (
        .i_clk     (clk),
        .i_rstz    (rstz),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_a     (cpu_a),
        .cpu_wd    (cpu_wd),
        .cpu_gnt   (cpu_gnt),
        .cpu_rvld  (cpu_rvld),
        .cpu_rd    (cpu_rd),
        .dma_req   (dma_req),
        .dma_we    (dma_we),
        .dma_a     (dma_a),
        .dma_wd    (dma_wd),
        .dma_gnt   (dma_gnt),
        .dma_rvld  (dma_rvld),
        .dma_rd    (dma_rd),
        .SRAM_CEB  (sram_ceb),
        .SRAM_WEB  (sram_web),
        .SRAM_OEB  (sram_oeb),
        .SRAM_A    (sram_a),
        .SRAM_D    (sram_d),
        .SRAM_RDAT (sram_rdat),
        .err_oor   (err_oor),
        .starve_hit(starve_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_ceb) begin
            if (!sram_web) mem[sram_a] <= sram_d;
            else if (!sram_oeb) sram_rdat <= mem[sram_a];
        end
    end

    task automatic step(input logic cr, input logic cw, input logic [10:0] ca, input logic [7:0] cd,
                        input logic dr, input logic dw, input logic [10:0] da, input logic [7:0] dd);
        @(posedge clk);
        #1;
        cpu_req = cr; cpu_we = cw; cpu_a = ca; cpu_wd = cd;
        dma_req = dr; dma_we = dw; dma_a = da; dma_wd = dd;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #12;
        vec++; if ({cpu_gnt, dma_gnt} !== 2'b00) begin miss++; $display("FAIL reset_gnt: got %b expected 00", {cpu_gnt, dma_gnt}); end
        vec++; if ({cpu_rvld, dma_rvld, err_oor, starve_hit} !== 4'b0000) begin miss++; $display("FAIL reset_flags: got %b expected 0000", {cpu_rvld, dma_rvld, err_oor, starve_hit}); end
        vec++; if ({sram_ceb, sram_web, sram_oeb} !== 3'b111) begin miss++; $display("FAIL reset_strobes: got %b expected 111", {sram_ceb, sram_web, sram_oeb}); end
        vec++; if ({sram_a, sram_d} !== 19'h0) begin miss++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", sram_a, sram_d); end
        vec++; if ({cpu_rd, dma_rd} !== 16'h0) begin miss++; $display("FAIL reset_rd: got %h/%h expected 00/00", cpu_rd, dma_rd); end
        @(posedge clk);
        #1;
        rstz = 1'b1;
        cpu_req = 1'b0; dma_req = 1'b0;
    endtask

    task automatic test_write_read();
        step(1, 1, 11'h010, 8'h5A, 0, 0, 0, 0);
        vec++; if ({cpu_gnt, dma_gnt} !== 2'b10) begin miss++; $display("FAIL wr_gnt: got %b expected 10", {cpu_gnt, dma_gnt}); end
        vec++; if ({sram_ceb, sram_web, sram_oeb, sram_a, sram_d} !== {3'b001, 11'h010, 8'h5A}) begin miss++; $display("FAIL wr_sram: got %b %h %h expected 001 010 5a", {sram_ceb, sram_web, sram_oeb}, sram_a, sram_d); end
        step(1, 0, 11'h010, 8'h00, 0, 0, 0, 0);
        vec++; if ({cpu_gnt, sram_ceb, sram_web, sram_oeb} !== 4'b1010) begin miss++; $display("FAIL rd_gnt: got %b expected 1010", {cpu_gnt, sram_ceb, sram_web, sram_oeb}); end
        step(0, 0, 11'h000, 8'h00, 0, 0, 0, 0);
        vec++; if ({cpu_rvld, cpu_rd, dma_rvld} !== {1'b1, 8'h5A, 1'b0}) begin miss++; $display("FAIL rd_data: got rvld=%b rd=%h dma_rvld=%b expected 1 5a 0", cpu_rvld, cpu_rd, dma_rvld); end
        vec++; if ({sram_ceb, sram_web, sram_oeb, sram_a, sram_d} !== {3'b111, 11'h010, 8'h00}) begin miss++; $display("FAIL idle_hold: got %b %h %h expected 111 010 00", {sram_ceb, sram_web, sram_oeb}, sram_a, sram_d); end
        step(0, 0, 11'h000, 8'h00, 0, 0, 0, 0);
        vec++; if ({cpu_rvld, cpu_rd} !== {1'b0, 8'h5A}) begin miss++; $display("FAIL rd_hold: got rvld=%b rd=%h expected 0 5a", cpu_rvld, cpu_rd); end
    endtask

    task automatic test_contention();
        logic exp_dma;
        for (int c = 1; c <= 6; c++) begin
            step(1, 0, 11'h020, 8'h00, 1, 0, 11'h030, 8'h00);
`ifdef XDAT_ARB_STARVE_EN
            exp_dma = (c == 5);
`else
            exp_dma = 1'b0;
`endif
            vec++; if ({cpu_gnt, dma_gnt, starve_hit} !== {!exp_dma, exp_dma, exp_dma}) begin miss++; $display("FAIL contention_c%0d: got cpu=%b dma=%b hit=%b expected %b %b %b", c, cpu_gnt, dma_gnt, starve_hit, !exp_dma, exp_dma, exp_dma); end
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_oor();
        step(0, 0, 0, 0, 1, 1, 11'h600, 8'h33);
        vec++; if ({dma_gnt, sram_ceb, err_oor} !== 3'b111) begin miss++; $display("FAIL oor_wr: got gnt=%b ceb=%b err=%b expected 1 1 1", dma_gnt, sram_ceb, err_oor); end
        step(0, 0, 0, 0, 1, 0, 11'h7FF, 8'h00);
        vec++; if ({dma_gnt, sram_ceb, err_oor} !== 3'b111) begin miss++; $display("FAIL oor_rd: got gnt=%b ceb=%b err=%b expected 1 1 1", dma_gnt, sram_ceb, err_oor); end
        step(1, 1, 11'h5FF, 8'hC3, 0, 0, 0, 0);
        vec++; if ({dma_rvld, dma_rd, cpu_rvld} !== {1'b1, 8'hFF, 1'b0}) begin miss++; $display("FAIL oor_rdata: got rvld=%b rd=%h cpu_rvld=%b expected 1 ff 0", dma_rvld, dma_rd, cpu_rvld); end
        vec++; if ({cpu_gnt, sram_ceb, err_oor} !== 3'b100) begin miss++; $display("FAIL last_word_wr: got gnt=%b ceb=%b err=%b expected 1 0 0", cpu_gnt, sram_ceb, err_oor); end
        step(1, 0, 11'h5FF, 8'h00, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        vec++; if ({cpu_rvld, cpu_rd, err_oor} !== {1'b1, 8'hC3, 1'b0}) begin miss++; $display("FAIL last_word_rd: got rvld=%b rd=%h err=%b expected 1 c3 0", cpu_rvld, cpu_rd, err_oor); end
    endtask

    task automatic test_reset_mid_read();
        step(1, 0, 11'h010, 8'h00, 0, 0, 0, 0);
        vec++; if (cpu_gnt !== 1'b1) begin miss++; $display("FAIL rst_pre_gnt: got %b expected 1", cpu_gnt); end
        @(posedge clk);
        #1;
        rstz = 1'b0;
        cpu_req = 1'b0;
        @(negedge clk);
        vec++; if ({cpu_rvld, dma_rvld, sram_ceb, sram_web, sram_oeb} !== 5'b00111) begin miss++; $display("FAIL rst_mid_flags: got %b expected 00111", {cpu_rvld, dma_rvld, sram_ceb, sram_web, sram_oeb}); end
        vec++; if ({cpu_rd, dma_rd, sram_a, sram_d} !== 35'h0) begin miss++; $display("FAIL rst_mid_data: got %h %h %h %h expected all 0", cpu_rd, dma_rd, sram_a, sram_d); end
        @(posedge clk);
        #1;
        rstz = 1'b1;
        @(negedge clk);
        vec++; if ({cpu_rvld, dma_rvld} !== 2'b00) begin miss++; $display("FAIL rst_release_rvld: got %b expected 00", {cpu_rvld, dma_rvld}); end
        step(1, 0, 11'h010, 8'h00, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        vec++; if ({cpu_rvld, cpu_rd} !== {1'b1, 8'h5A}) begin miss++; $display("FAIL rst_post_read: got rvld=%b rd=%h expected 1 5a", cpu_rvld, cpu_rd); end
    endtask

    task automatic test_hazard();
        step(1, 1, 11'h040, 8'h77, 1, 0, 11'h040, 8'h00);
        vec++; if ({cpu_gnt, dma_gnt, sram_web} !== 3'b100) begin miss++; $display("FAIL hazard_first: got %b expected 100", {cpu_gnt, dma_gnt, sram_web}); end
        step(0, 0, 0, 0, 1, 0, 11'h040, 8'h00);
        vec++; if (dma_gnt !== 1'b1) begin miss++; $display("FAIL hazard_dma_gnt: got %b expected 1", dma_gnt); end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        vec++; if ({dma_rvld, dma_rd} !== {1'b1, 8'h77}) begin miss++; $display("FAIL hazard_data: got rvld=%b rd=%h expected 1 77", dma_rvld, dma_rd); end
    endtask

    task automatic test_back_to_back();
        step(1, 1, 11'h001, 8'h11, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 11'h002, 8'h22);
        step(1, 0, 11'h001, 8'h00, 1, 0, 11'h002, 8'h00);
        vec++; if ({cpu_gnt, dma_gnt} !== 2'b10) begin miss++; $display("FAIL b2b_a_gnt: got %b expected 10", {cpu_gnt, dma_gnt}); end
        step(0, 0, 0, 0, 1, 0, 11'h002, 8'h00);
        vec++; if ({dma_gnt, cpu_rvld, cpu_rd, dma_rvld} !== {1'b1, 1'b1, 8'h11, 1'b0}) begin miss++; $display("FAIL b2b_b: got gnt=%b crvld=%b crd=%h drvld=%b expected 1 1 11 0", dma_gnt, cpu_rvld, cpu_rd, dma_rvld); end
        step(1, 0, 11'h002, 8'h00, 0, 0, 0, 0);
        vec++; if ({cpu_gnt, dma_rvld, dma_rd, cpu_rvld, cpu_rd} !== {1'b1, 1'b1, 8'h22, 1'b0, 8'h11}) begin miss++; $display("FAIL b2b_c: got gnt=%b drvld=%b drd=%h crvld=%b crd=%h expected 1 1 22 0 11", cpu_gnt, dma_rvld, dma_rd, cpu_rvld, cpu_rd); end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        vec++; if ({cpu_rvld, cpu_rd, dma_rvld, dma_rd} !== {1'b1, 8'h22, 1'b0, 8'h22}) begin miss++; $display("FAIL b2b_d: got crvld=%b crd=%h drvld=%b drd=%h expected 1 22 0 22", cpu_rvld, cpu_rd, dma_rvld, dma_rd); end
    endtask

    initial begin
        vec = 0;
        miss = 0;
        for (int i = 0; i < 1536; i++) mem[i] = 8'h00;
        sram_rdat = 8'h00;
        rstz = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 11'h123; cpu_wd = 8'hAB;
        dma_req = 1'b1; dma_we = 1'b0; dma_a = 11'h321; dma_wd = 8'hCD;
        test_reset();
        test_write_read();
        test_contention();
        test_oor();
        test_reset_mid_read();
        test_hazard();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
